// File: rtl/board_pkt_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : board_pkt_rx                                              |
// | Brief    : 8N1 UART receiver for the inter-board link. Oversamples   |
// |            the line, assembles PKT_LEN/8 bytes (byte 0 first, LSB    |
// |            first) into one packet and pulses ready with it. A long   |
// |            idle gap aborts a partially received packet.              |
// | Config   : RX_MAJORITY_EN - 2-of-3 majority vote around mid-bit      |
// |            (default: single sample at mid-bit)                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module board_pkt_rx #(
    parameter int CLK_HZ        = 65_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int SAMP_PER_BIT  = 16,
    parameter int CLK_PER_SAMP  = 423,
    parameter int PKT_LEN       = 208,
    parameter int WAITING_COUNT = 130_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    localparam int c_NBYTES = PKT_LEN / 8;
    localparam int c_CW     = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int c_SW     = $clog2(SAMP_PER_BIT);
    localparam int c_BW     = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam int c_GW     = $clog2(WAITING_COUNT + 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    localparam logic [c_CW-1:0] c_TICK_LAST = c_CW'(CLK_PER_SAMP - 1);
    localparam logic [c_SW-1:0] c_SAMP_LAST = c_SW'(SAMP_PER_BIT - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(WAITING_COUNT - 1);
    localparam logic [c_BW-1:0] c_BYTE_LAST = c_BW'(c_NBYTES - 1);

    // Sample position (ticks into the current bit) at which a bit is decided.
`ifdef RX_MAJORITY_EN
    localparam logic [c_SW-1:0] c_SAMP_LO  = c_SW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [c_SW-1:0] c_SAMP_MID = c_SW'(SAMP_PER_BIT / 2);
    localparam logic [c_SW-1:0] c_SAMP_DEC = c_SW'(SAMP_PER_BIT / 2 + 1);
`else
    localparam logic [c_SW-1:0] c_SAMP_DEC = c_SW'(SAMP_PER_BIT / 2);
`endif

    // Reject parameter sets the datapath cannot represent.
    generate
        if (((PKT_LEN % 8) != 0) || (SAMP_PER_BIT < 4) || (CLK_PER_SAMP < 1) ||
            ((CLK_HZ / BAUD_RATE) < SAMP_PER_BIT)) begin : g_cfg_bad
            $error("board_pkt_rx: unsupported parameter combination");
        end
    endgenerate

    logic              r_rx_meta;
    logic              r_rxs;
    logic              r_rxs_prev;
    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_clk_cnt;
    logic [c_SW-1:0]   r_samp_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [c_BW-1:0]   r_byte_cnt;
    logic [c_GW-1:0]   r_gap;
    logic [PKT_LEN-1:0] r_pkt;
`ifdef RX_MAJORITY_EN
    logic [1:0]        r_hist;
`endif

    logic              w_fall;
    logic              w_tick;
    logic [c_SW-1:0]   w_samp_next;
    logic              w_decide;
    logic              w_bit;
    logic              w_last;
    logic [PKT_LEN-1:0] w_pkt_next;

    // Tick/edge detection, bit decision and the packet with the current byte merged in.
    always_comb begin
        w_fall      = r_rxs_prev & ~r_rxs;
        w_tick      = (r_clk_cnt == c_TICK_LAST);
        w_samp_next = (r_samp_cnt == c_SAMP_LAST) ? '0 : r_samp_cnt + 1'b1;
        w_decide    = w_tick && (w_samp_next == c_SAMP_DEC);
`ifdef RX_MAJORITY_EN
        w_bit       = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxs) | (r_hist[0] & r_rxs);
`else
        w_bit       = r_rxs;
`endif
        w_last      = (r_byte_cnt == c_BYTE_LAST);
        w_pkt_next  = r_pkt;
        w_pkt_next[{r_byte_cnt, 3'b000} +: 8] = r_shift;
    end

    // Synchroniser, sample timing and the receive state machine with registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_state    <= c_ST_IDLE;
            r_clk_cnt  <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_gap      <= '0;
            r_pkt      <= '0;
`ifdef RX_MAJORITY_EN
            r_hist     <= '0;
`endif
            ready      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            data_out   <= '0;
        end else begin
            r_rx_meta  <= rx;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
            ready      <= 1'b0;
            frame_err  <= 1'b0;
            r_clk_cnt  <= w_tick ? '0 : r_clk_cnt + 1'b1;
            if (w_tick) begin
                r_samp_cnt <= w_samp_next;
            end
`ifdef RX_MAJORITY_EN
            // The two samples ahead of the decision point feed the vote.
            if (w_tick && ((w_samp_next == c_SAMP_LO) || (w_samp_next == c_SAMP_MID))) begin
                r_hist <= {r_hist[0], r_rxs};
            end
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        // Realign the sample grid to the start edge.
                        r_gap      <= '0;
                        r_clk_cnt  <= '0;
                        r_samp_cnt <= '0;
                        r_state    <= c_ST_START;
                    end else if ((r_byte_cnt != '0) && r_rxs) begin
                        if (r_gap == c_GAP_LAST) begin
                            r_gap      <= '0;
                            r_byte_cnt <= '0;
                            r_pkt      <= '0;
                            busy       <= 1'b0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                c_ST_START: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            // False start: partial packet is kept.
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_bit_cnt <= '0;
                            r_state   <= c_ST_DATA;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            if (w_last) begin
                                data_out   <= w_pkt_next;
                                ready      <= 1'b1;
                                r_pkt      <= '0;
                                r_byte_cnt <= '0;
                                busy       <= 1'b0;
                            end else begin
                                r_pkt      <= w_pkt_next;
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                                busy       <= 1'b1;
                            end
                            r_state <= c_ST_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            r_pkt      <= '0;
                            r_byte_cnt <= '0;
                            busy       <= 1'b0;
                            r_gap      <= '0;
                            r_state    <= c_ST_ERR;
                        end
                    end
                end
                c_ST_ERR: begin
                    // Line must stay high for a full waiting period before re-arming.
                    if (!r_rxs) begin
                        r_gap <= '0;
                    end else if (r_gap == c_GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_pkt_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_board_pkt_rx                                           |
// | Brief    : Self-checking bench for board_pkt_rx (2-byte packets,     |
// |            4 clocks per sample, 2000-clock idle abort).              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_board_pkt_rx;

    localparam int SPB      = 16;
    localparam int CPS      = 4;
    localparam int PKT      = 16;
    localparam int WC       = 2000;
    localparam int NB       = PKT / 8;
    localparam int BIT_CLKS = SPB * CPS;
    // Idle long enough to clear both the partial-packet abort and the error hold-off.
    localparam int LONG_GAP = WC + 100;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           rx     = 1'b1;
    logic           ready;
    logic           frame_err;
    logic           busy;
    logic [PKT-1:0] data_out;

    board_pkt_rx #(
        .SAMP_PER_BIT (SPB),
        .CLK_PER_SAMP (CPS),
        .PKT_LEN      (PKT),
        .WAITING_COUNT(WC)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .ready    (ready),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Observed activity, sampled on the falling edge.
    logic [PKT-1:0] got_pkts[$];
    int             got_ferr    = 0;
    int             both_high   = 0;
    int             ready_long  = 0;
    int             data_glitch = 0;
    logic           prev_ready  = 1'b0;
    logic [PKT-1:0] prev_data   = '0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_ready = 1'b0;
            prev_data  = data_out;
        end else begin
            if (ready) got_pkts.push_back(data_out);
            if (frame_err) got_ferr++;
            if (ready && frame_err) both_high++;
            if (ready && prev_ready) ready_long++;
            if (!ready && (data_out !== prev_data)) data_glitch++;
            prev_ready = ready;
            prev_data  = data_out;
        end
    end

    // Reference model: bytes of the packet in progress and the packets owed.
    logic [7:0]     pend[$];
    logic [PKT-1:0] exp_pkts[$];
    logic [PKT-1:0] exp_data = '0;
    int             exp_ferr = 0;
    int             n_cmp    = 0;

    task automatic model_frame(input logic [7:0] b, input logic stop);
        logic [PKT-1:0] p;
        if (!stop) begin
            pend.delete();
            exp_ferr++;
        end else begin
            pend.push_back(b);
            if (pend.size() == NB) begin
                p = '0;
                for (int k = 0; k < NB; k++) p[8*k +: 8] = pend[k];
                exp_pkts.push_back(p);
                exp_data = p;
                pend.delete();
            end
        end
    endtask

    task automatic model_gap(input int n);
        if (n >= WC) pend.delete();
    endtask

    task automatic model_reset();
        pend.delete();
        exp_data = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " pkt_count"}, 64'(got_pkts.size()), 64'(exp_pkts.size()));
        while ((n_cmp < got_pkts.size()) && (n_cmp < exp_pkts.size())) begin
            chk({tag, " pkt_data"}, 64'(got_pkts[n_cmp]), 64'(exp_pkts[n_cmp]));
            n_cmp++;
        end
        chk({tag, " data_out"}, 64'(data_out), 64'(exp_data));
        chk({tag, " frame_err_count"}, 64'(got_ferr), 64'(exp_ferr));
        chk({tag, " busy"}, 64'(busy), 64'(pend.size() != 0));
    endtask

    task automatic line_hold(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clk_in);
    endtask

    // One 8N1 frame; glitch_bit >= 0 inverts that frame bit for one sample period at mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == glitch_bit) begin
                line_hold(f[i], BIT_CLKS / 2 - 2);
                line_hold(~f[i], CPS);
                line_hold(f[i], BIT_CLKS - (BIT_CLKS / 2 - 2) - CPS);
            end else begin
                line_hold(f[i], BIT_CLKS);
            end
        end
        rx = 1'b1;
        model_frame(b, stop);
    endtask

    task automatic gap(input int n);
        line_hold(1'b1, n);
        model_gap(n);
    endtask

    logic [7:0] rb;
    logic       rbad;
    logic [7:0] pb;

    initial begin
        rst_in = 1'b1;
        rx     = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset frame_err", 64'(frame_err), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset data_out", 64'(data_out), 64'd0);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);

        // Basic packet
        send_frame(8'hA5, 1'b1, -1);
        check_state("t1 byte0");
        send_frame(8'h3C, 1'b1, -1);
        check_state("t1 packet");
        chk("t1 value", 64'(data_out), 64'h3CA5);
        gap(100);

        // Bad stop bit, then recovery after the hold-off
        send_frame(8'h12, 1'b0, -1);
        check_state("t2 frame_err");
        gap(LONG_GAP);
        send_frame(8'h34, 1'b1, -1);
        gap(20);
        send_frame(8'h56, 1'b1, -1);
        check_state("t2 packet");
        chk("t2 value", 64'(data_out), 64'h5634);
        gap(100);

        // Idle timeout drops a lone first byte
        send_frame(8'h11, 1'b1, -1);
        check_state("t3 byte0");
        gap(2500);
        check_state("t3 after idle");
        send_frame(8'h22, 1'b1, -1);
        gap(20);
        send_frame(8'h33, 1'b1, -1);
        check_state("t3 packet");
        chk("t3 value", 64'(data_out), 64'h3322);
        gap(100);

        // One-sample glitch on an idle line
        line_hold(1'b0, CPS);
        line_hold(1'b1, 200);
        check_state("t4 idle glitch");
        chk("t4 ready", 64'(ready), 64'd0);
`ifdef RX_MAJORITY_EN
        send_frame(8'hA5, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 4);
        check_state("t4 data glitch");
        chk("t4 value", 64'(data_out), 64'h3CA5);
        gap(100);
`endif

        // Reset in the middle of bit 3 of byte 1
        send_frame(8'h77, 1'b1, -1);
        check_state("t5 byte0");
        pb = 8'hC8;
        line_hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) line_hold(pb[i], BIT_CLKS);
        line_hold(pb[3], BIT_CLKS / 2);
        #2 rst_in = 1'b1;
        #1;
        chk("t5 rst ready", 64'(ready), 64'd0);
        chk("t5 rst frame_err", 64'(frame_err), 64'd0);
        chk("t5 rst busy", 64'(busy), 64'd0);
        chk("t5 rst data_out", 64'(data_out), 64'd0);
        model_reset();
        @(negedge clk_in);
        rx = 1'b1;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        line_hold(1'b1, 100);
        check_state("t5 after reset");
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        check_state("t5 packet");
        chk("t5 value", 64'(data_out), 64'h00FF);
        gap(100);

        // Back-to-back packets, no idle between frames
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        check_state("t6 packet0");
        chk("t6 value0", 64'(data_out), 64'h0201);
        send_frame(8'h03, 1'b1, -1);
        send_frame(8'h04, 1'b1, -1);
        check_state("t6 packet1");
        chk("t6 value1", 64'(data_out), 64'h0403);
        gap(100);

        // Random traffic: random bytes, occasional bad stop bits and long gaps
        for (int i = 0; i < 30; i++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 7) == 0);
            send_frame(rb, ~rbad, -1);
            check_state("rand");
            if (rbad) gap(LONG_GAP + int'($urandom_range(0, 200)));
            else if ($urandom_range(0, 7) == 0) gap(LONG_GAP + int'($urandom_range(0, 400)));
            else gap(int'($urandom_range(0, 150)));
        end
        check_state("final");

        chk("ready single-cycle", 64'(ready_long), 64'd0);
        chk("ready/frame_err exclusive", 64'(both_high), 64'd0);
        chk("data_out stable outside ready", 64'(data_glitch), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
